// File: rtl/pwm_ramp_sequencer_if.sv
// Command/status bundle between the ramp sequencer and its controller.
// The master drives the setpoint and strobes; the slave returns the command and status.
interface pwm_ramp_sequencer_if #(
  parameter int W  = 16,
  parameter int DW = 16
);
  logic                enable;
  logic                estop;
  logic                tick;
  logic signed [W-1:0] target;
  logic [W-2:0]        step;
  logic [DW-1:0]       dwell;
  logic signed [W-1:0] pwm_cmd;
  logic                at_target;
  logic                reversing;
  logic                busy;

  modport master (
    output enable, estop, tick, target, step, dwell,
    input  pwm_cmd, at_target, reversing, busy
  );

  modport slave (
    input  enable, estop, tick, target, step, dwell,
    output pwm_cmd, at_target, reversing, busy
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Slew-rate limiter for the signed PWM command: ramps toward the target by at most
// step per tick and passes through zero, with a dwell, before any direction reversal.
module pwm_ramp_sequencer #(
  parameter int W  = 16,
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_ramp_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam logic signed [W-1:0] MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] CLAMP_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] ZERO_CMD  = {W{1'b0}};

  // One slew step from cur toward eff; the difference is formed one bit wider.
  function automatic logic signed [W-1:0] ramp_f(
    input logic signed [W-1:0] cur,
    input logic signed [W-1:0] eff,
    input logic [W-2:0]        stp
  );
    logic signed [W:0] diff;
    logic [W:0]        mag;
    logic signed [W-1:0] res;
    diff = {eff[W-1], eff} - {cur[W-1], cur};
    mag  = diff[W] ? (~diff + {{W{1'b0}}, 1'b1}) : diff;
    if (mag <= {2'b00, stp}) begin
      res = eff;
    end else if (diff[W]) begin
      res = cur - {1'b0, stp};
    end else begin
      res = cur + {1'b0, stp};
    end
    return res;
  endfunction

  state_t              state_r, state_n;
  logic signed [W-1:0] pwm_cmd_r, pwm_n;
  logic [DW-1:0]       dwell_cnt_r, cnt_n;
  logic [1:0]          last_dir_r, dir_n;   // [0] valid, [1] negative
  logic                at_target_r, reversing_r, busy_r;
  logic signed [W-1:0] tgt_c_s, eff_s, ramp_s;
  logic                opposite_s;

  // Clamp the target, detect a direction request and pick the effective target.
  always_comb begin
    tgt_c_s    = (bus.target == MOST_NEG) ? CLAMP_NEG : bus.target;
    opposite_s = (tgt_c_s != ZERO_CMD) && last_dir_r[0] && (tgt_c_s[W-1] != last_dir_r[1]);
    if (!bus.enable) begin
      eff_s = ZERO_CMD;
    end else if (opposite_s && (pwm_cmd_r != ZERO_CMD)) begin
      eff_s = ZERO_CMD;
    end else begin
      eff_s = tgt_c_s;
    end
    ramp_s = ramp_f(pwm_cmd_r, eff_s, bus.step);
  end

  // Next-state, command and direction-memory logic.
  always_comb begin
    state_n = state_r;
    pwm_n   = pwm_cmd_r;
    cnt_n   = dwell_cnt_r;
    dir_n   = last_dir_r;
    if (bus.estop) begin
      state_n = ST_IDLE;
      pwm_n   = ZERO_CMD;
      cnt_n   = {DW{1'b0}};
      dir_n   = 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pwm_n = ZERO_CMD;
          dir_n = 2'b00;
          if (bus.enable) begin
            state_n = ST_RUN;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!bus.tick) begin
            state_n = ST_RUN;
          end else if (!bus.enable && (pwm_cmd_r == ZERO_CMD)) begin
            state_n = ST_IDLE;
            dir_n   = 2'b00;
          end else if ((pwm_cmd_r == ZERO_CMD) && opposite_s) begin
            // last_dir is kept through the dwell so the reversal stays pending
            state_n = ST_DWELL;
            cnt_n   = bus.dwell;
          end else begin
            pwm_n = ramp_s;
            if (ramp_s != ZERO_CMD) begin
              dir_n = {ramp_s[W-1], 1'b1};
            end else begin
              dir_n = last_dir_r;
            end
          end
        end
        ST_DWELL: begin
          pwm_n = ZERO_CMD;
          if (!bus.tick) begin
            state_n = ST_DWELL;
          end else if (!bus.enable) begin
            state_n = ST_IDLE;
            dir_n   = 2'b00;
          end else if (dwell_cnt_r == {DW{1'b0}}) begin
            state_n = ST_RUN;
            dir_n   = 2'b00;
          end else begin
            cnt_n = dwell_cnt_r - {{(DW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_n = ST_IDLE;
          pwm_n   = ZERO_CMD;
          cnt_n   = {DW{1'b0}};
          dir_n   = 2'b00;
        end
      endcase
    end
  end

  // State, command and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pwm_cmd_r   <= ZERO_CMD;
      dwell_cnt_r <= {DW{1'b0}};
      last_dir_r  <= 2'b00;
      at_target_r <= 1'b0;
      reversing_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      pwm_cmd_r   <= pwm_n;
      dwell_cnt_r <= cnt_n;
      last_dir_r  <= dir_n;
      at_target_r <= (state_n == ST_RUN) && (pwm_n == tgt_c_s);
      reversing_r <= (state_n == ST_DWELL);
      busy_r      <= (state_n != ST_IDLE);
    end
  end

  assign bus.pwm_cmd   = pwm_cmd_r;
  assign bus.at_target = at_target_r;
  assign bus.reversing = reversing_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: ramp, reversal with dwell, clamp,
// estop, disable-to-idle and asynchronous reset during dwell.
module tb_pwm_ramp_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pwm_ramp_sequencer_if #(.W(16), .DW(16)) bus ();

  pwm_ramp_sequencer #(.W(16), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // A short gap, then a one-clock tick; returns 1 time unit after the sampling edge.
  task automatic do_tick();
    clk1();
    clk1();
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int cmd, input int at_t, input int rev, input int bsy);
    chk({tag, ".pwm_cmd"},   $signed(bus.pwm_cmd), cmd);
    chk({tag, ".at_target"}, {31'd0, bus.at_target}, at_t);
    chk({tag, ".reversing"}, {31'd0, bus.reversing}, rev);
    chk({tag, ".busy"},      {31'd0, bus.busy}, bsy);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.estop  = 1'b0;
    bus.tick   = 1'b0;
    bus.target = 16'sd0;
    bus.step   = 15'd0;
    bus.dwell  = 16'd0;
    repeat (3) clk1();
    chk_status("reset", 0, 0, 0, 0);

    // 1: ramp 0 -> 1000 in steps of 100
    bus.target = 16'sd1000;
    bus.step   = 15'd100;
    bus.enable = 1'b1;
    rst_n      = 1'b1;
    clk1();
    chk_status("t1_start", 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      do_tick();
      chk("t1_ramp", $signed(bus.pwm_cmd), 100 * i);
      chk("t1_at_target", {31'd0, bus.at_target}, (i == 10) ? 1 : 0);
    end
    do_tick();
    chk_status("t1_stable", 1000, 1, 0, 1);

    // down to +300 before the reversal test
    bus.target = 16'sd300;
    for (int i = 1; i <= 7; i++) begin
      do_tick();
    end
    chk_status("t1_at300", 300, 1, 0, 1);

    // 2: reversal 300 -> -200 with dwell 3
    bus.target = -16'sd200;
    bus.dwell  = 16'd3;
    do_tick();
    chk_status("t2_200", 200, 0, 0, 1);
    do_tick();
    chk_status("t2_100", 100, 0, 0, 1);
    do_tick();
    chk_status("t2_0", 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk_status("t2_dwell", 0, 0, 1, 1);
    end
    do_tick();
    chk_status("t2_dwell_end", 0, 0, 0, 1);
    do_tick();
    chk_status("t2_m100", -100, 0, 0, 1);
    do_tick();
    chk_status("t2_m200", -200, 1, 0, 1);

    // 3: back to 0, then full-scale negative step with clamp
    bus.target = 16'sd0;
    do_tick();
    do_tick();
    chk_status("t3_zero", 0, 1, 0, 1);
    bus.target = -16'sd32768;
    bus.step   = 15'd32767;
    do_tick();
    chk_status("t3_clamp", -32767, 1, 0, 1);

    // 4: reverse with dwell=0 up to +500, then estop
    bus.target = 16'sd0;
    bus.dwell  = 16'd0;
    do_tick();
    chk("t4_zero", $signed(bus.pwm_cmd), 0);
    bus.target = 16'sd500;
    do_tick();
    chk_status("t4_dwell0", 0, 0, 1, 1);
    do_tick();
    chk_status("t4_dwell0_end", 0, 0, 0, 1);
    do_tick();
    chk_status("t4_500", 500, 1, 0, 1);
    bus.target = 16'sd1000;
    bus.step   = 15'd100;
    clk1();
    bus.estop = 1'b1;
    bus.tick  = 1'b1;
    clk1();
    bus.tick  = 1'b0;
    chk_status("t4_estop", 0, 0, 0, 0);
    do_tick();
    do_tick();
    chk_status("t4_estop_hold", 0, 0, 0, 0);
    bus.estop = 1'b0;
    clk1();
    chk_status("t4_restart", 0, 0, 0, 1);
    do_tick();
    chk_status("t4_ramp", 100, 0, 0, 1);

    // 5: disable at 250 -> 150, 50, 0, IDLE, then restart
    bus.target = 16'sd250;
    bus.step   = 15'd150;
    do_tick();
    chk("t5_250", $signed(bus.pwm_cmd), 250);
    bus.enable = 1'b0;
    bus.step   = 15'd100;
    do_tick();
    chk_status("t5_150", 150, 0, 0, 1);
    do_tick();
    chk_status("t5_50", 50, 0, 0, 1);
    do_tick();
    chk_status("t5_0", 0, 0, 0, 1);
    do_tick();
    chk_status("t5_idle", 0, 0, 0, 0);
    clk1();
    chk("t5_idle_hold", {31'd0, bus.busy}, 0);
    bus.target = 16'sd300;
    bus.enable = 1'b1;
    clk1();
    chk("t5_run", {31'd0, bus.busy}, 1);
    do_tick();
    chk_status("t5_ramp", 100, 0, 0, 1);

    // 6: async reset while in DWELL
    bus.target = -16'sd100;
    bus.dwell  = 16'd5;
    do_tick();
    chk("t6_zero", $signed(bus.pwm_cmd), 0);
    do_tick();
    chk_status("t6_dwell", 0, 0, 1, 1);
    #1;
    rst_n = 1'b0;
    #2;
    chk_status("t6_async", 0, 0, 0, 0);
    clk1();
    rst_n = 1'b1;
    clk1();
    chk_status("t6_run", 0, 0, 0, 1);
    do_tick();
    chk_status("t6_ramp", -100, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
